// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: valid/ready pipeline stage with one head register and optional skid register.
// Define PIPE_STAGE_BUF_SKID_EN for two entries with a registered in_ready; otherwise one entry.
module pipe_stage_buf #(
    parameter int DATA_W = 32,
    parameter int LANES  = 7
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W*LANES-1:0]   in_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W*LANES-1:0]   out_data,
    output logic [1:0]                occupancy
);
    localparam int W = DATA_W * LANES;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;
    state_t state;
    logic [W-1:0] head;
`ifdef PIPE_STAGE_BUF_SKID_EN
    logic [W-1:0] skid;
`endif
    // rdy is low through reset and rises on the first edge after release
    logic rdy;
    logic in_xfer, out_xfer;
    assign out_valid = state != EMPTY;
    assign out_data  = out_valid ? head : '0;
    assign occupancy = state;
`ifdef PIPE_STAGE_BUF_SKID_EN
    assign in_ready  = rdy;
`else
    assign in_ready  = rdy && (state == EMPTY || out_ready);
`endif
    assign in_xfer  = in_valid && in_ready;
    assign out_xfer = out_valid && out_ready;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= EMPTY;
            head  <= '0;
`ifdef PIPE_STAGE_BUF_SKID_EN
            skid  <= '0;
`endif
            rdy   <= 1'b0;
        end else if (flush) begin
            state <= EMPTY;
            head  <= '0;
`ifdef PIPE_STAGE_BUF_SKID_EN
            skid  <= '0;
`endif
            rdy   <= 1'b1;
        end else begin
            rdy <= 1'b1;
            case (state)
                EMPTY: if (in_xfer) begin
                    head  <= in_data;
                    state <= ONE;
                end
                ONE: if (in_xfer && out_xfer) begin
                    head <= in_data;
`ifdef PIPE_STAGE_BUF_SKID_EN
                end else if (in_xfer) begin
                    skid  <= in_data;
                    state <= FULL;
                    rdy   <= 1'b0;
`endif
                end else if (out_xfer) begin
                    state <= EMPTY;
                end
`ifdef PIPE_STAGE_BUF_SKID_EN
                FULL: if (out_xfer) begin
                    head  <= skid;
                    skid  <= '0;
                    state <= ONE;
                end else begin
                    rdy <= 1'b0;
                end
`endif
                default: state <= EMPTY;
            endcase
        end
    end
endmodule
